ulpi_result_tx: RTL and testbench



---
 rtl/ulpi_result_tx.sv | 93 +++++++++
 tb/tb_ulpi_result_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_result_tx.sv
`default_nettype none
// ============================================================================
// ulpi_result_tx : queues 16-bit result words, sends each to UART Tx as two
// bytes, MSB first.                                          Revision 1.0
// ============================================================================
module ulpi_result_tx #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        res_push,
  input  logic [15:0] res_msg,
  output logic        res_full,
  output logic        res_empty,
  output logic        res_overflow,
  input  logic        UART_Tx_FULL,
  output logic [7:0]  UART_Tx_DATA,
  output logic        UART_Tx_PUSH
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_SEND_HI = 2'd2;
  localparam logic [1:0] S_SEND_LO = 2'd3;

  logic [15:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [15:0] msg_r;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        overflow_r;
  logic        push_ok;
  logic        pop;

  assign res_empty    = (wr_ptr == rd_ptr);
  assign res_full     = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign res_overflow = overflow_r;
  assign push_ok      = res_push & ~res_full;

  // Storage carries no reset; resetting the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr[AW-1:0]] <= res_msg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      msg_r      <= 16'h0000;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (res_push && res_full)
        overflow_r <= 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        msg_r  <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:    state_nxt = res_empty ? S_IDLE : S_LOAD;
      S_LOAD:    state_nxt = S_SEND_HI;
      S_SEND_HI: state_nxt = UART_Tx_FULL ? S_SEND_HI : S_SEND_LO;
      S_SEND_LO: state_nxt = UART_Tx_FULL ? S_SEND_LO : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop          = (state == S_LOAD) && !res_empty;
    UART_Tx_PUSH = ((state == S_SEND_HI) || (state == S_SEND_LO)) && !UART_Tx_FULL;
    UART_Tx_DATA = (state == S_SEND_HI) ? msg_r[15:8] : msg_r[7:0];
  end

endmodule
`default_nettype wire

// File: tb/tb_ulpi_result_tx.sv
`default_nettype none
// Directed testbench for ulpi_result_tx: captures every UART strobe and
// compares against hand-computed byte streams and flag values.
module tb_ulpi_result_tx;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        res_push = 1'b0;
  logic [15:0] res_msg = 16'h0000;
  logic        res_full;
  logic        res_empty;
  logic        res_overflow;
  logic        UART_Tx_FULL = 1'b0;
  logic [7:0]  UART_Tx_DATA;
  logic        UART_Tx_PUSH;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [7:0] bq[$];
  int         tq[$];

  ulpi_result_tx #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .res_push(res_push), .res_msg(res_msg),
    .res_full(res_full), .res_empty(res_empty), .res_overflow(res_overflow),
    .UART_Tx_FULL(UART_Tx_FULL), .UART_Tx_DATA(UART_Tx_DATA),
    .UART_Tx_PUSH(UART_Tx_PUSH)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (UART_Tx_PUSH) begin
      bq.push_back(UART_Tx_DATA);
      tq.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the word is captured on the following posedge.
  task automatic push_word(input logic [15:0] w);
    res_push = 1'b1;
    res_msg  = w;
    @(negedge clk);
    res_push = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] exp[$]);
    check({tag, "_len"}, bq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < bq.size(); i++)
      check($sformatf("%s_b%0d", tag, i), bq[i], exp[i]);
  endtask

  logic [7:0] exp_q[$];

  initial begin
    // Reset state
    #1;
    check("rst_empty", res_empty, 1);
    check("rst_full", res_full, 0);
    check("rst_ovf", res_overflow, 0);
    check("rst_push", UART_Tx_PUSH, 0);
    check("rst_data", UART_Tx_DATA, 8'h00);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(2);

    // Single word with cycle-exact latency
    bq.delete(); tq.delete();
    push_word(16'hA55A);
    check("sw_empty_n1", res_empty, 0);
    check("sw_push_n1", UART_Tx_PUSH, 0);
    wait_cyc(1);
    check("sw_push_load", UART_Tx_PUSH, 0);
    wait_cyc(1);
    check("sw_push_hi", UART_Tx_PUSH, 1);
    check("sw_data_hi", UART_Tx_DATA, 8'hA5);
    check("sw_empty_hi", res_empty, 1);
    wait_cyc(1);
    check("sw_push_lo", UART_Tx_PUSH, 1);
    check("sw_data_lo", UART_Tx_DATA, 8'h5A);
    wait_cyc(1);
    check("sw_push_idle", UART_Tx_PUSH, 0);
    wait_cyc(4);
    exp_q = '{8'hA5, 8'h5A};
    check_stream("sw", exp_q);

    // Burst of three words: contiguous bytes, 4-cycle word spacing
    bq.delete(); tq.delete();
    push_word(16'h0102);
    push_word(16'h0304);
    push_word(16'h0506);
    wait_cyc(16);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    check_stream("burst", exp_q);
    if (tq.size() == 6) begin
      for (int w = 0; w < 3; w++)
        check($sformatf("burst_gap%0d", w), tq[2*w+1] - tq[2*w], 1);
      check("burst_space01", tq[2] - tq[0], 4);
      check("burst_space12", tq[4] - tq[2], 4);
    end else begin
      check("burst_stamps", tq.size(), 6);
    end

    // Backpressure in SEND_HI
    bq.delete(); tq.delete();
    UART_Tx_FULL = 1'b1;
    push_word(16'h1234);
    wait_cyc(2);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_push%0d", i), UART_Tx_PUSH, 0);
      check($sformatf("bp_hold_data%0d", i), UART_Tx_DATA, 8'h12);
      if (i < 4) wait_cyc(1);
    end
    UART_Tx_FULL = 1'b0;
    #1;
    check("bp_rel_push", UART_Tx_PUSH, 1);
    check("bp_rel_data", UART_Tx_DATA, 8'h12);
    wait_cyc(1);
    check("bp_lo_push", UART_Tx_PUSH, 1);
    check("bp_lo_data", UART_Tx_DATA, 8'h34);
    wait_cyc(4);
    exp_q = '{8'h12, 8'h34};
    check_stream("bp", exp_q);

    // Full / overflow: FSM parked in SEND_HI on 0xBEEF, so no pops occur
    bq.delete(); tq.delete();
    UART_Tx_FULL = 1'b1;
    push_word(16'hBEEF);
    wait_cyc(2);
    for (int i = 0; i <= DEPTH; i++) begin
      push_word(i[15:0]);
      if (i < DEPTH) check($sformatf("ovf_full%0d", i), res_full, (i == DEPTH-1) ? 1 : 0);
    end
    check("ovf_full_end", res_full, 1);
    check("ovf_flag", res_overflow, 1);
    check("ovf_nobytes", bq.size(), 0);
    UART_Tx_FULL = 1'b0;
    wait_cyc(4 * (DEPTH + 1) + 8);
    exp_q = '{8'hBE, 8'hEF};
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h00);
      exp_q.push_back(i[7:0]);
    end
    check_stream("ovf", exp_q);
    check("ovf_sticky", res_overflow, 1);
    check("ovf_empty", res_empty, 1);

    // Push during LOAD at occupancy 1
    bq.delete(); tq.delete();
    push_word(16'h1111);
    wait_cyc(1);
    push_word(16'h2222);
    check("sim_empty", res_empty, 0);
    check("sim_full", res_full, 0);
    check("sim_push_hi", UART_Tx_PUSH, 1);
    check("sim_data_hi", UART_Tx_DATA, 8'h11);
    wait_cyc(10);
    check("sim_empty_end", res_empty, 1);
    exp_q = '{8'h11, 8'h11, 8'h22, 8'h22};
    check_stream("sim", exp_q);

    // Mid-word reset in SEND_LO with a second word still queued
    bq.delete(); tq.delete();
    push_word(16'hC3D4);
    push_word(16'hE5F6);
    wait_cyc(2);
    check("mr_push_lo", UART_Tx_PUSH, 1);
    check("mr_data_lo", UART_Tx_DATA, 8'hD4);
    rst = 1'b0;
    #1;
    check("mr_push", UART_Tx_PUSH, 0);
    check("mr_empty", res_empty, 1);
    check("mr_ovf", res_overflow, 0);
    check("mr_data", UART_Tx_DATA, 8'h00);
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(12);
    exp_q = '{8'hC3};
    check_stream("mr", exp_q);
    check("mr_empty_after", res_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire
